// File: rtl/pose_score_accumulator.sv
// pose_score_accumulator: realigns scorer distances with the delayed user skeleton,
// accumulates clamped distance per frame and computes the mean with a restoring divider.
module pose_score_accumulator #(
    parameter int HRES = 320,
    parameter int VRES = 180,
    parameter int SCORER_LATENCY = 3,
    parameter int CLAMP = 64,
    parameter int THRESHOLD = 8,
    localparam int HWIDTH = $clog2(HRES),
    localparam int VWIDTH = $clog2(VRES),
    localparam int DWIDTH = $clog2(HRES + VRES + 1),
    localparam int CWIDTH = $clog2(HRES * VRES + 1),
    localparam int SWIDTH = $clog2(HRES * VRES * CLAMP + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [HWIDTH-1:0] hcount_in,
    input  logic [VWIDTH-1:0] vcount_in,
    input  logic              pixel_in,
    input  logic              valid_in,
    output logic [HWIDTH-1:0] query_hcount_out,
    output logic [VWIDTH-1:0] query_vcount_out,
    input  logic [HWIDTH-1:0] dist_hcount_in,
    input  logic [VWIDTH-1:0] dist_vcount_in,
    input  logic [DWIDTH-1:0] distance_in,
    input  logic              distance_valid_in,
    output logic [DWIDTH-1:0] score_out,
    output logic              match_out,
    output logic              score_valid_out,
    output logic              frame_dropped_out,
    output logic              busy_out
);
    localparam int D = 1 + SCORER_LATENCY;
    localparam int IWIDTH = $clog2(SWIDTH);
    localparam logic [DWIDTH-1:0] CLAMP_D = (CLAMP >= (1 << DWIDTH)) ? {DWIDTH{1'b1}} : DWIDTH'(CLAMP);

    typedef enum logic {A_IDLE, A_ACCUM} acc_t;
    typedef enum logic [1:0] {D_IDLE, D_DIV, D_DONE} div_t;

    acc_t r_acc_state;
    div_t r_div_state;
    logic [D-1:0] r_sr_valid, r_sr_pix;
    logic [HWIDTH-1:0] r_sr_h [D];
    logic [VWIDTH-1:0] r_sr_v [D];
    logic [SWIDTH-1:0] r_sum, r_dvd, r_quo;
    logic [CWIDTH-1:0] r_cnt, r_den, r_rem;
    logic [IWIDTH-1:0] r_iter;
    logic r_bad;

    logic w_first, w_last, w_active, w_mis, w_bad_nxt, w_start, w_ge;
    logic [SWIDTH-1:0] w_dist, w_clip, w_sum_nxt, w_quo_nxt;
    logic [CWIDTH-1:0] w_cnt_nxt, w_rem_nxt;
    logic [CWIDTH:0] w_trial;
    logic [DWIDTH-1:0] w_score;

    assign w_first = r_sr_valid[D-1] && r_sr_h[D-1] == '0 && r_sr_v[D-1] == '0;
    assign w_last = r_sr_valid[D-1] && r_sr_h[D-1] == HWIDTH'(HRES - 1) && r_sr_v[D-1] == VWIDTH'(VRES - 1);
    assign w_active = w_first || (r_acc_state == A_ACCUM && r_sr_valid[D-1]);
    assign w_mis = !distance_valid_in || dist_hcount_in != r_sr_h[D-1] || dist_vcount_in != r_sr_v[D-1];
    assign w_dist = SWIDTH'(distance_in);
    assign w_clip = (w_dist > SWIDTH'(CLAMP)) ? SWIDTH'(CLAMP) : w_dist;
    assign w_sum_nxt = (w_first ? '0 : r_sum) + (r_sr_pix[D-1] ? w_clip : '0);
    assign w_cnt_nxt = (w_first ? '0 : r_cnt) + CWIDTH'(r_sr_pix[D-1]);
    assign w_bad_nxt = (!w_first && r_bad) || w_mis;
    assign w_start = w_active && w_last && !w_bad_nxt;

    assign w_trial = {r_rem, r_dvd[SWIDTH-1]};
    assign w_ge = w_trial >= {1'b0, r_den};
    assign w_rem_nxt = w_ge ? CWIDTH'(w_trial - {1'b0, r_den}) : CWIDTH'(w_trial);
    assign w_quo_nxt = {r_quo[SWIDTH-2:0], w_ge};
    assign w_score = (|w_quo_nxt[SWIDTH-1:DWIDTH]) ? {DWIDTH{1'b1}} : w_quo_nxt[DWIDTH-1:0];
    assign busy_out = r_div_state != D_IDLE;

    always_ff @(posedge clk_in) begin
        r_sr_pix <= {r_sr_pix[D-2:0], pixel_in};
        r_sr_h[0] <= hcount_in;
        r_sr_v[0] <= vcount_in;
        for (int i = 1; i < D; i++) begin
            r_sr_h[i] <= r_sr_h[i-1];
            r_sr_v[i] <= r_sr_v[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sr_valid <= '0;
            query_hcount_out <= '0;
            query_vcount_out <= '0;
            r_acc_state <= A_IDLE;
            r_sum <= '0;
            r_cnt <= '0;
            r_bad <= 1'b0;
            frame_dropped_out <= 1'b0;
        end else begin
            r_sr_valid <= {r_sr_valid[D-2:0], valid_in};
            query_hcount_out <= hcount_in;
            query_vcount_out <= vcount_in;
            frame_dropped_out <= w_active && w_last && w_bad_nxt;
            if (w_active) begin
                r_sum <= w_sum_nxt;
                r_cnt <= w_cnt_nxt;
                r_bad <= w_bad_nxt;
                r_acc_state <= w_last ? A_IDLE : A_ACCUM;
            end
        end
    end

    // The last quotient bit and the result load share one edge so busy drops as the pulse rises.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div_state <= D_IDLE;
            r_den <= '0;
            r_dvd <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_iter <= '0;
            score_out <= '0;
            match_out <= 1'b0;
            score_valid_out <= 1'b0;
        end else begin
            score_valid_out <= 1'b0;
            if (w_start) begin
                r_den <= w_cnt_nxt;
                r_dvd <= w_sum_nxt;
                r_rem <= '0;
                r_quo <= '0;
                r_iter <= IWIDTH'(SWIDTH - 1);
                r_div_state <= (w_cnt_nxt == '0) ? D_DONE : D_DIV;
            end else if (r_div_state == D_DIV) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_dvd <= r_dvd << 1;
                r_iter <= r_iter - 1'b1;
                if (r_iter == '0) begin
                    score_out <= w_score;
                    match_out <= 32'(w_score) <= THRESHOLD;
                    score_valid_out <= 1'b1;
                    r_div_state <= D_IDLE;
                end
            end else if (r_div_state == D_DONE) begin
                score_out <= CLAMP_D;
                match_out <= 1'b0;
                score_valid_out <= 1'b1;
                r_div_state <= D_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pose_score_accumulator.sv
// tb_pose_score_accumulator: ideal-scorer harness with directed vector table, random frames
// and a reset-during-divide sequence, checked against an arithmetic mean model.
module tb_pose_score_accumulator;
    localparam int HRES = 40, VRES = 30, LAT = 3, CLAMP = 64, THR = 8;
    localparam int HW = $clog2(HRES), VW = $clog2(VRES), DW = $clog2(HRES + VRES + 1);
    localparam int SW = $clog2(HRES * VRES * CLAMP + 1), N = HRES * VRES, D = 1 + LAT;

    logic clk_in = 1'b0, rst_in = 1'b1;
    logic [HW-1:0] hcount_in = '0, query_hcount_out, dist_hcount_in;
    logic [VW-1:0] vcount_in = '0, query_vcount_out, dist_vcount_in;
    logic pixel_in = 1'b0, valid_in = 1'b0, distance_valid_in;
    logic [DW-1:0] distance_in, score_out;
    logic match_out, score_valid_out, frame_dropped_out, busy_out;

    pose_score_accumulator #(.HRES(HRES), .VRES(VRES), .SCORER_LATENCY(LAT), .CLAMP(CLAMP), .THRESHOLD(THR)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .pixel_in(pixel_in), .valid_in(valid_in), .query_hcount_out(query_hcount_out),
        .query_vcount_out(query_vcount_out), .dist_hcount_in(dist_hcount_in), .dist_vcount_in(dist_vcount_in),
        .distance_in(distance_in), .distance_valid_in(distance_valid_in), .score_out(score_out),
        .match_out(match_out), .score_valid_out(score_valid_out), .frame_dropped_out(frame_dropped_out),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Ideal scorer: echoes the query coordinates after LAT cycles with a distance from a table.
    logic [HW-1:0] p_h [LAT];
    logic [VW-1:0] p_v [LAT];
    int fault = 0;
    logic user [N];
    logic [DW-1:0] dmem [N];
    always @(posedge clk_in) begin
        p_h[0] <= query_hcount_out;
        p_v[0] <= query_vcount_out;
        for (int i = 1; i < LAT; i++) begin
            p_h[i] <= p_h[i-1];
            p_v[i] <= p_v[i-1];
        end
    end
    always_comb begin
        dist_hcount_in = p_h[LAT-1] + HW'(fault == 2);
        dist_vcount_in = p_v[LAT-1];
        distance_valid_in = !(fault == 1 && p_h[LAT-1] == HW'(10) && p_v[LAT-1] == VW'(5));
        distance_in = (int'(p_h[LAT-1]) < HRES && int'(p_v[LAT-1]) < VRES) ?
                      dmem[int'(p_v[LAT-1]) * HRES + int'(p_h[LAT-1])] : '0;
    end

    int n_valid = 0, n_drop = 0, n_busy = 0, valid_cyc = 0, drop_cyc = 0;
    always @(negedge clk_in) if (!rst_in) begin
        if (score_valid_out) begin n_valid++; valid_cyc = cyc; end
        if (frame_dropped_out) begin n_drop++; drop_cyc = cyc; end
        if (busy_out) n_busy++;
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int h, input int vv, input logic p);
        @(posedge clk_in); #1;
        valid_in = v; hcount_in = HW'(h); vcount_in = VW'(vv); pixel_in = p;
    endtask

    task automatic build(input int na, input int da, input int nb, input int db);
        for (int p = 0; p < N; p++) begin user[p] = 1'b0; dmem[p] = DW'($urandom_range(0, 127)); end
        for (int i = 0; i < na + nb; i++) begin
            user[1 + (i * 7) % (N - 1)] = 1'b1;
            dmem[1 + (i * 7) % (N - 1)] = DW'(i < na ? da : db);
        end
    endtask

    task automatic model(output int sc, output int mt, output int cnt);
        int s;
        s = 0; cnt = 0;
        for (int p = 0; p < N; p++) if (user[p]) begin
            s += (int'(dmem[p]) > CLAMP) ? CLAMP : int'(dmem[p]);
            cnt++;
        end
        if (cnt == 0) begin sc = CLAMP; mt = 0; end
        else begin
            sc = s / cnt;
            if (sc > (1 << DW) - 1) sc = (1 << DW) - 1;
            mt = int'(sc <= THR);
        end
    endtask

    task automatic run_frame(input int exp_drop, input int exp_sc, input int exp_mt, input int cnt, input string tag);
        int b_v, b_d, b_b, prev, t_last;
        b_v = n_valid; b_d = n_drop; b_b = n_busy; prev = int'(score_out);
        for (int v = 0; v < VRES; v++)
            for (int h = 0; h < HRES; h++) drive(1'b1, h, v, user[v * HRES + h]);
        t_last = cyc;
        repeat (SW + 12) drive(1'b0, 0, 0, 1'b0);
        if (exp_drop != 0) begin
            chk({tag, " drop pulses"}, n_drop - b_d, 1);
            chk({tag, " drop cycle"}, drop_cyc, t_last + D + 1);
            chk({tag, " no score pulse"}, n_valid - b_v, 0);
            chk({tag, " score kept"}, int'(score_out), prev);
        end else begin
            chk({tag, " score pulses"}, n_valid - b_v, 1);
            chk({tag, " score cycle"}, valid_cyc, t_last + D + (cnt == 0 ? 2 : SW + 1));
            chk({tag, " busy cycles"}, n_busy - b_b, cnt == 0 ? 1 : SW);
            chk({tag, " no drop"}, n_drop - b_d, 0);
            chk({tag, " score"}, int'(score_out), exp_sc);
            chk({tag, " match"}, int'(match_out), exp_mt);
        end
    endtask

    typedef struct { int na; int da; int nb; int db; int flt; int drop; int sc; int mt; } vec_t;
    vec_t tbl [10];

    initial begin
        int sc, mt, cnt, dens, dmax, b_v;
        tbl[0] = '{1, 5, 0, 0, 0, 0, 5, 1};
        tbl[1] = '{50, 3, 50, 6, 0, 0, 4, 1};
        tbl[2] = '{100, 127, 0, 0, 0, 0, 64, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 64, 0};
        tbl[4] = '{20, 8, 0, 0, 0, 0, 8, 1};
        tbl[5] = '{20, 9, 0, 0, 0, 0, 9, 0};
        tbl[6] = '{30, 65, 30, 64, 0, 0, 64, 0};
        tbl[7] = '{10, 2, 0, 0, 1, 1, 0, 0};
        tbl[8] = '{10, 2, 0, 0, 2, 1, 0, 0};
        tbl[9] = '{3, 0, 1, 7, 0, 0, 1, 1};
        hcount_in = HW'(5); vcount_in = VW'(3);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset query_h", int'(query_hcount_out), 0);
        chk("reset query_v", int'(query_vcount_out), 0);
        chk("reset score", int'(score_out), 0);
        chk("reset match", int'(match_out), 0);
        chk("reset valid", int'(score_valid_out), 0);
        chk("reset drop", int'(frame_dropped_out), 0);
        chk("reset busy", int'(busy_out), 0);
        @(posedge clk_in); #1 rst_in = 1'b0;
        drive(1'b0, 7, 3, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        @(negedge clk_in);
        chk("query_h", int'(query_hcount_out), 7);
        chk("query_v", int'(query_vcount_out), 3);
        for (int i = 0; i < 10; i++) begin
            build(tbl[i].na, tbl[i].da, tbl[i].nb, tbl[i].db);
            fault = tbl[i].flt;
            model(sc, mt, cnt);
            run_frame(tbl[i].drop, tbl[i].sc, tbl[i].mt, cnt, $sformatf("vec%0d", i));
            fault = 0;
        end
        for (int r = 0; r < 4; r++) begin
            dens = $urandom_range(0, 30);
            dmax = $urandom_range(4, 127);
            for (int p = 0; p < N; p++) begin
                user[p] = (p != 0) && ($urandom_range(0, 99) < dens);
                dmem[p] = DW'($urandom_range(0, dmax));
            end
            model(sc, mt, cnt);
            run_frame(0, sc, mt, cnt, $sformatf("rnd%0d", r));
        end
        build(1, 5, 0, 0);
        for (int v = 0; v < VRES; v++)
            for (int h = 0; h < HRES; h++) drive(1'b1, h, v, user[v * HRES + h]);
        repeat (D + 3) drive(1'b0, 0, 0, 1'b0);
        @(negedge clk_in);
        chk("busy before reset", int'(busy_out), 1);
        b_v = n_valid;
        @(posedge clk_in); #1 rst_in = 1'b1;
        @(posedge clk_in); #1 rst_in = 1'b0;
        @(negedge clk_in);
        chk("busy after reset", int'(busy_out), 0);
        repeat (SW + 8) drive(1'b0, 0, 0, 1'b0);
        chk("no score after reset", n_valid - b_v, 0);
        chk("score cleared by reset", int'(score_out), 0);
        build(50, 3, 50, 6);
        model(sc, mt, cnt);
        run_frame(0, 4, 1, cnt, "post-reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
